// File: rtl/pipeline_trace_buffer.sv
// Retire-trace capture: records WB retirements in a circular buffer, stops after a PC trigger plus a post window.
// Optional macro TRACE_PC_MASK_EN adds a trig_mask input for masked PC matching.
module pipeline_trace_buffer #(
    parameter int NSTAGE    = 5,
    parameter int PC_W      = 32,
    parameter int DATA_W    = 32,
    parameter int DEPTH     = 16,
    parameter int POST_TRIG = 8
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  logic                       arm,
    input  logic [PC_W-1:0]            trig_pc,
`ifdef TRACE_PC_MASK_EN
    input  logic [PC_W-1:0]            trig_mask,
`endif
    input  logic [NSTAGE-1:0]          stage_valid,
    input  logic [PC_W-1:0]            wb_pc,
    input  logic [DATA_W-1:0]          wb_data,
    input  logic [$clog2(DEPTH)-1:0]   rd_idx,
    output logic [PC_W-1:0]            rd_pc,
    output logic [DATA_W-1:0]          rd_data,
    output logic [1:0]                 state,
    output logic [$clog2(DEPTH):0]     entry_cnt,
    output logic [31:0]                bubble_cnt,
    output logic                       done
);
    localparam int AW = $clog2(DEPTH);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ARMED = 2'd1;
    localparam logic [1:0] S_TRIG  = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [PC_W+DATA_W-1:0] r_mem [DEPTH];
    logic [1:0]             r_state;
    logic [AW-1:0]          r_wptr;
    logic [AW:0]            r_entry_cnt;
    logic [AW-1:0]          r_post;
    logic [31:0]            r_bubble_cnt;
    logic [PC_W-1:0]        r_rd_pc;
    logic [DATA_W-1:0]      r_rd_data;

    logic                   w_retire;
    logic                   w_capturing;
    logic                   w_match;
    logic                   w_wr_en;
    logic [AW-1:0]          w_rd_addr;

    assign w_retire    = stage_valid[NSTAGE-1];
    assign w_capturing = (r_state == S_ARMED) || (r_state == S_TRIG);
`ifdef TRACE_PC_MASK_EN
    assign w_match     = ((wb_pc & trig_mask) == (trig_pc & trig_mask));
`else
    assign w_match     = (wb_pc == trig_pc);
`endif
    assign w_wr_en     = resetn && !arm && w_capturing && w_retire;
    // Oldest entry sits entry_cnt slots behind the write pointer; modulo wrap comes from the AW-bit width.
    assign w_rd_addr   = r_wptr - r_entry_cnt[AW-1:0] + rd_idx;

    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[r_wptr] <= {wb_pc, wb_data};
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state      <= S_IDLE;
            r_wptr       <= '0;
            r_entry_cnt  <= '0;
            r_post       <= '0;
            r_bubble_cnt <= '0;
        end else if (arm) begin
            r_state      <= S_ARMED;
            r_wptr       <= '0;
            r_entry_cnt  <= '0;
            r_post       <= '0;
            r_bubble_cnt <= '0;
        end else begin
            if (w_capturing && w_retire) begin
                r_wptr <= r_wptr + 1'b1;
                if (r_entry_cnt != (AW+1)'(DEPTH)) begin
                    r_entry_cnt <= r_entry_cnt + 1'b1;
                end
            end
            if (w_capturing && !(&stage_valid) && (r_bubble_cnt != '1)) begin
                r_bubble_cnt <= r_bubble_cnt + 1'b1;
            end
            if ((r_state == S_ARMED) && w_retire && w_match) begin
                r_post  <= AW'(POST_TRIG);
                r_state <= (POST_TRIG == 0) ? S_DONE : S_TRIG;
            end else if ((r_state == S_TRIG) && w_retire) begin
                r_post <= r_post - 1'b1;
                if (r_post == AW'(1)) begin
                    r_state <= S_DONE;
                end
            end
        end
    end

    // Registered readback samples RAM before any same-cycle write lands.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_rd_pc   <= '0;
            r_rd_data <= '0;
        end else if ({1'b0, rd_idx} >= r_entry_cnt) begin
            r_rd_pc   <= '0;
            r_rd_data <= '0;
        end else begin
            {r_rd_pc, r_rd_data} <= r_mem[w_rd_addr];
        end
    end

    assign rd_pc      = r_rd_pc;
    assign rd_data    = r_rd_data;
    assign state      = r_state;
    assign entry_cnt  = r_entry_cnt;
    assign bubble_cnt = r_bubble_cnt;
    assign done       = (r_state == S_DONE);

endmodule

// File: tb/tb_pipeline_trace_buffer.sv
// Self-checking bench for pipeline_trace_buffer: readback expectations go through a scoreboard queue.
module tb_pipeline_trace_buffer;
    logic        clk = 1'b0;
    logic        resetn;
    logic        arm;
    logic [31:0] trig_pc;
    logic [4:0]  stage_valid;
    logic [31:0] wb_pc;
    logic [31:0] wb_data;
    logic [3:0]  rd_idx;
    logic [31:0] rd_pc;
    logic [31:0] rd_data;
    logic [1:0]  state;
    logic [4:0]  entry_cnt;
    logic [31:0] bubble_cnt;
    logic        done;

    int errors = 0;
    int checks = 0;

    int          q_idx[$];
    logic [31:0] q_pc[$];
    logic [31:0] q_dat[$];

    always #5 clk = ~clk;

    pipeline_trace_buffer dut (
        .clk         (clk),
        .resetn      (resetn),
        .arm         (arm),
        .trig_pc     (trig_pc),
`ifdef TRACE_PC_MASK_EN
        .trig_mask   (32'hFFFF_FFFF),
`endif
        .stage_valid (stage_valid),
        .wb_pc       (wb_pc),
        .wb_data     (wb_data),
        .rd_idx      (rd_idx),
        .rd_pc       (rd_pc),
        .rd_data     (rd_data),
        .state       (state),
        .entry_cnt   (entry_cnt),
        .bubble_cnt  (bubble_cnt),
        .done        (done)
    );

    function automatic logic [31:0] dfun(input logic [31:0] pc);
        return pc ^ 32'hA5A5_0000;
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_arm(input logic [31:0] tpc);
        trig_pc     = tpc;
        arm         = 1'b1;
        stage_valid = 5'b00000;
        cyc();
        arm = 1'b0;
    endtask

    task automatic retire(input logic [31:0] pc);
        stage_valid = 5'b11111;
        wb_pc       = pc;
        wb_data     = dfun(pc);
        cyc();
    endtask

    task automatic expect_rd(input int idx, input logic [31:0] pc, input bit empty);
        q_idx.push_back(idx);
        q_pc.push_back(empty ? 32'h0 : pc);
        q_dat.push_back(empty ? 32'h0 : dfun(pc));
    endtask

    task automatic rd(input int idx, output logic [31:0] p, output logic [31:0] d);
        rd_idx = 4'(idx);
        cyc();
        p = rd_pc;
        d = rd_data;
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        repeat (10) cyc();
        resetn = 1'b1;
        cyc();
        checks++; if (state !== 2'd0) begin errors++; $display("FAIL reset_state got=%0d exp=0", state); end
        checks++; if (entry_cnt !== 5'd0) begin errors++; $display("FAIL reset_entry got=%0d exp=0", entry_cnt); end
        checks++; if (bubble_cnt !== 32'd0) begin errors++; $display("FAIL reset_bubble got=%0d exp=0", bubble_cnt); end
        checks++; if (rd_pc !== 32'd0) begin errors++; $display("FAIL reset_rd_pc got=%h exp=0", rd_pc); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", done); end
    endtask

    task automatic test_basic();
        logic [31:0] p, d, ep, ed;
        int idx;
        do_arm(32'hDEAD_0000);
        for (int k = 0; k < 5; k++) retire(32'hBFC0_0000 + 32'(4 * k));
        stage_valid = 5'b00000;
        checks++; if (entry_cnt !== 5'd5) begin errors++; $display("FAIL basic_entry got=%0d exp=5", entry_cnt); end
        checks++; if (state !== 2'd1) begin errors++; $display("FAIL basic_state got=%0d exp=1", state); end
        expect_rd(0, 32'hBFC0_0000, 1'b0);
        expect_rd(4, 32'hBFC0_0010, 1'b0);
        expect_rd(5, 32'h0, 1'b1);
        while (q_idx.size() > 0) begin
            idx = q_idx.pop_front(); ep = q_pc.pop_front(); ed = q_dat.pop_front();
            rd(idx, p, d);
            checks++; if (p !== ep) begin errors++; $display("FAIL basic_rd_pc[%0d] got=%h exp=%h", idx, p, ep); end
            checks++; if (d !== ed) begin errors++; $display("FAIL basic_rd_data[%0d] got=%h exp=%h", idx, d, ed); end
        end
    endtask

    task automatic test_wrap();
        logic [31:0] p, d, ep, ed;
        int idx;
        do_arm(32'hDEAD_0000);
        for (int k = 0; k < 20; k++) retire(32'hBFC0_0000 + 32'(4 * k));
        stage_valid = 5'b00000;
        checks++; if (entry_cnt !== 5'd16) begin errors++; $display("FAIL wrap_entry got=%0d exp=16", entry_cnt); end
        expect_rd(0, 32'hBFC0_0010, 1'b0);
        expect_rd(7, 32'hBFC0_002C, 1'b0);
        expect_rd(15, 32'hBFC0_004C, 1'b0);
        while (q_idx.size() > 0) begin
            idx = q_idx.pop_front(); ep = q_pc.pop_front(); ed = q_dat.pop_front();
            rd(idx, p, d);
            checks++; if (p !== ep) begin errors++; $display("FAIL wrap_rd_pc[%0d] got=%h exp=%h", idx, p, ep); end
            checks++; if (d !== ed) begin errors++; $display("FAIL wrap_rd_data[%0d] got=%h exp=%h", idx, d, ed); end
        end
    endtask

    task automatic test_trigger();
        logic [31:0] p, d, ep, ed, pc;
        int idx;
        do_arm(32'h0000_0020);
        for (int k = 0; k <= 24; k++) begin
            pc = 32'(4 * k);
            retire(pc);
            if (pc == 32'h20) begin
                checks++; if (state !== 2'd2) begin errors++; $display("FAIL trig_state_after_20 got=%0d exp=2", state); end
            end
            if (pc == 32'h3C) begin
                checks++; if (done !== 1'b0) begin errors++; $display("FAIL trig_done_early got=%b exp=0", done); end
            end
            if (pc == 32'h40) begin
                checks++; if (state !== 2'd3) begin errors++; $display("FAIL trig_state_after_40 got=%0d exp=3", state); end
                checks++; if (done !== 1'b1) begin errors++; $display("FAIL trig_done got=%b exp=1", done); end
            end
        end
        stage_valid = 5'b00000;
        checks++; if (entry_cnt !== 5'd16) begin errors++; $display("FAIL trig_entry got=%0d exp=16", entry_cnt); end
        checks++; if (state !== 2'd3) begin errors++; $display("FAIL trig_state_final got=%0d exp=3", state); end
        expect_rd(0, 32'h0000_0004, 1'b0);
        expect_rd(15, 32'h0000_0040, 1'b0);
        while (q_idx.size() > 0) begin
            idx = q_idx.pop_front(); ep = q_pc.pop_front(); ed = q_dat.pop_front();
            rd(idx, p, d);
            checks++; if (p !== ep) begin errors++; $display("FAIL trig_rd_pc[%0d] got=%h exp=%h", idx, p, ep); end
            checks++; if (d !== ed) begin errors++; $display("FAIL trig_rd_data[%0d] got=%h exp=%h", idx, d, ed); end
        end
    endtask

    task automatic test_bubbles();
        do_arm(32'hDEAD_0000);
        for (int k = 0; k < 4; k++) retire(32'h1000_0000 + 32'(4 * k));
        stage_valid = 5'b01111;
        repeat (3) cyc();
        checks++; if (bubble_cnt !== 32'd3) begin errors++; $display("FAIL bubble_cnt got=%0d exp=3", bubble_cnt); end
        checks++; if (entry_cnt !== 5'd4) begin errors++; $display("FAIL bubble_entry got=%0d exp=4", entry_cnt); end
        stage_valid = 5'b00000;
    endtask

    task automatic test_arm_collision();
        logic [31:0] p, d, ep, ed;
        int idx;
        do_arm(32'h0000_0014);
        for (int k = 0; k < 6; k++) retire(32'(4 * k));
        checks++; if (state !== 2'd2) begin errors++; $display("FAIL coll_pre_state got=%0d exp=2", state); end
        checks++; if (entry_cnt !== 5'd6) begin errors++; $display("FAIL coll_pre_entry got=%0d exp=6", entry_cnt); end
        arm         = 1'b1;
        stage_valid = 5'b11111;
        wb_pc       = 32'h18;
        wb_data     = dfun(32'h18);
        cyc();
        arm         = 1'b0;
        stage_valid = 5'b11111;
        checks++; if (state !== 2'd1) begin errors++; $display("FAIL coll_state got=%0d exp=1", state); end
        checks++; if (entry_cnt !== 5'd0) begin errors++; $display("FAIL coll_entry got=%0d exp=0", entry_cnt); end
        checks++; if (bubble_cnt !== 32'd0) begin errors++; $display("FAIL coll_bubble got=%0d exp=0", bubble_cnt); end
        stage_valid = 5'b00000;
        expect_rd(0, 32'h0, 1'b1);
        while (q_idx.size() > 0) begin
            idx = q_idx.pop_front(); ep = q_pc.pop_front(); ed = q_dat.pop_front();
            rd(idx, p, d);
            checks++; if (p !== ep) begin errors++; $display("FAIL coll_rd_pc[%0d] got=%h exp=%h", idx, p, ep); end
            checks++; if (d !== ed) begin errors++; $display("FAIL coll_rd_data[%0d] got=%h exp=%h", idx, d, ed); end
        end
    endtask

    initial begin
        resetn      = 1'b0;
        arm         = 1'b0;
        trig_pc     = 32'h0;
        stage_valid = 5'b00000;
        wb_pc       = 32'h0;
        wb_data     = 32'h0;
        rd_idx      = 4'd0;
        test_reset();
        test_basic();
        test_wrap();
        test_trigger();
        test_bubbles();
        test_arm_collision();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
